// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - host-side handshake and serial-line bundle for uart_tx_frame
//
// Signals:
//   TXDATA    [7:0] byte to transmit (host -> tx)
//   TX_VALID        TXDATA valid (host -> tx)
//   PARITY_EN       append even parity to this byte's frame (host -> tx)
//   TXD             serial line, idles high (tx -> pin)
//   TX_READY        tx can accept a byte this cycle (tx -> host)
//   BUSY            a frame is being shifted out (tx -> host)
//   TX_DONE         one-cycle pulse in the last stop-bit cycle (tx -> host)
// Modports: master = host side, slave = transmitter side.

interface uart_tx_frame_if;
    logic [7:0] TXDATA;
    logic       TX_VALID;
    logic       PARITY_EN;
    logic       TXD;
    logic       TX_READY;
    logic       BUSY;
    logic       TX_DONE;

    modport master (
        output TXDATA, TX_VALID, PARITY_EN,
        input  TXD, TX_READY, BUSY, TX_DONE
    );

    modport slave (
        input  TXDATA, TX_VALID, PARITY_EN,
        output TXD, TX_READY, BUSY, TX_DONE
    );
endinterface

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, 8 data bits LSB first, optional even parity, stop
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  uart_tx_frame_if.slave (TXDATA, TX_VALID, PARITY_EN in; TXD, TX_READY, BUSY, TX_DONE out)
// Parameter:
//   CLKS_PER_BIT  clock cycles per serial bit, 1..65535
// Build option:
//   UART_TX_HOLD_BUF_EN  adds a one-entry holding register so frames can run back to back

module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 1
) (
    input logic            CLK,
    input logic            RST,
    uart_tx_frame_if.slave bus
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        par_en;
    logic        par_bit;
    logic        txd_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    logic accept;
    logic bit_end;

    assign accept  = bus.TX_VALID && ready_q;
    assign bit_end = (cnt == LAST);

    assign bus.TXD      = txd_q;
    assign bus.TX_READY = ready_q;
    assign bus.BUSY     = busy_q;
    assign bus.TX_DONE  = done_q;

`ifdef UART_TX_HOLD_BUF_EN
    logic       hold_full;
    logic [7:0] hold_data;
    logic       hold_pen;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            hold_full <= 1'b0;
            hold_data <= 8'd0;
            hold_pen  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
            // Mid-frame accept parks the byte; the STOP hand-off below overrides this
            // when the accept lands on the final stop cycle.
            if (state != IDLE && accept) begin
                hold_full <= 1'b1;
                hold_data <= bus.TXDATA;
                hold_pen  <= bus.PARITY_EN;
                ready_q   <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= bus.TXDATA;
                        par_en  <= bus.PARITY_EN;
                        par_bit <= ^bus.TXDATA;
                        state   <= START;
                        cnt     <= 16'd0;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                        ready_q <= 1'b1;
`else
                        ready_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        cnt     <= 16'd0;
                        bit_idx <= 3'd0;
                        txd_q   <= shreg[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            if (par_en) begin
                                state <= PARITY;
                                txd_q <= par_bit;
                            end else begin
                                state  <= STOP;
                                txd_q  <= 1'b1;
                                done_q <= (LAST == 16'd0);
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            txd_q   <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        cnt    <= 16'd0;
                        txd_q  <= 1'b1;
                        done_q <= (LAST == 16'd0);
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= 16'd0;
`ifdef UART_TX_HOLD_BUF_EN
                        // Chain straight into the next start bit when a byte is waiting.
                        if (hold_full || accept) begin
                            state     <= START;
                            txd_q     <= 1'b0;
                            ready_q   <= 1'b1;
                            hold_full <= 1'b0;
                            if (hold_full) begin
                                shreg   <= hold_data;
                                par_en  <= hold_pen;
                                par_bit <= ^hold_data;
                            end else begin
                                shreg   <= bus.TXDATA;
                                par_en  <= bus.PARITY_EN;
                                par_bit <= ^bus.TXDATA;
                            end
                        end else begin
                            state   <= IDLE;
                            txd_q   <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
`else
                        state   <= IDLE;
                        txd_q   <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt    <= cnt + 16'd1;
                        // Registered pulse: raise it one cycle ahead of the final stop cycle.
                        done_q <= ((cnt + 16'd1) == LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
